pll_reset_sequencer: RTL and testbench

Parametrised PLL supervisor and reset sequencer, next to the `SB_PLL40_CORE` wrapper. It drives the PLL reset and bypass controls and watches the lock indicator. Downstream resets are released, staggered, only after lock has been stable for a programmable time. On lock loss it re-asserts resets and re-initialises the PLL, with bounded retries and an optional bypass fallback. It runs on the PLL reference clock, never on the PLL output.

---
 rtl/clk_rst_pkg.sv | 31 +++
 rtl/sync_2ff.sv | 27 ++
 rtl/pll_reset_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_pll_reset_sequencer.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/clk_rst_pkg.sv
// Shared clock/reset types: sequencer state encoding, registered control flags
// and the width helper for the sequencer's shared timing counter.
package clk_rst_pkg;

   typedef enum logic [2:0] {
      ST_PLL_RST   = 3'd0,
      ST_WAIT_LOCK = 3'd1,
      ST_STABLE    = 3'd2,
      ST_RELEASE   = 3'd3,
      ST_RUN       = 3'd4,
      ST_FAIL      = 3'd5
   } seq_state_t;

   typedef struct packed {
      logic pll_reset;
      logic bypass;
      logic ready;
      logic fail;
   } seq_flags_t;

   // Bits needed to hold the largest of four cycle counts.
   function automatic int cnt_width(input int a, input int b, input int c, input int d);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return (m < 1) ? 1 : $clog2(m + 1);
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop bit synchroniser for asynchronous status inputs; the reset value
// of both stages is a parameter.
module sync_2ff #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta_reg;
   logic sync_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_reg <= RST_VAL;
         sync_reg <= RST_VAL;
      end else begin
         meta_reg <= d;
         sync_reg <= meta_reg;
      end
   end

   assign q = sync_reg;

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL supervisor: drives PLL reset/bypass, qualifies lock, releases downstream
// resets staggered, and re-initialises the PLL on lock loss with bounded retries.
module pll_reset_sequencer
   import clk_rst_pkg::*;
#(
   parameter int NUM_RST        = 4,
   parameter int PLL_RST_CYCLES = 16,
   parameter int LOCK_TIMEOUT   = 2500,
   parameter int LOCK_STABLE    = 250,
   parameter int STAGGER        = 8,
   parameter int MAX_RETRY      = 3,
   parameter int ALLOW_BYPASS   = 1,
   localparam int RETRY_W       = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1
) (
   input  logic               clk_in,
   input  logic               reset_n,
   input  logic               locked,
   input  logic               restart,
   output logic               pll_reset,
   output logic               bypass,
   output logic [NUM_RST-1:0] rst_n_out,
   output logic               ready,
   output logic               fail,
   output logic [RETRY_W-1:0] retry_cnt
);

   localparam int REL_LAST = (NUM_RST - 1) * STAGGER;
   localparam int CNT_W    = cnt_width(PLL_RST_CYCLES, LOCK_TIMEOUT, LOCK_STABLE, REL_LAST + 1);

   localparam logic [CNT_W-1:0]   CNT_PLL   = CNT_W'(PLL_RST_CYCLES - 1);
   localparam logic [CNT_W-1:0]   CNT_TO    = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0]   CNT_STB   = CNT_W'(LOCK_STABLE - 1);
   localparam logic [CNT_W-1:0]   CNT_REL   = CNT_W'(REL_LAST + 1);
   localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);

   logic               locked_s;
   seq_state_t         state_reg, state_next;
   logic [CNT_W-1:0]   cnt_reg, cnt_next;
   logic [RETRY_W-1:0] retry_reg, retry_next;
   seq_flags_t         flags_reg, flags_next;
   logic [NUM_RST-1:0] rst_n_reg, rst_n_next;
   logic [NUM_RST-1:0] rel_mask;

   sync_2ff #(
      .RST_VAL (1'b0)
   ) u_lock_sync (
      .clk   (clk_in),
      .rst_n (reset_n),
      .d     (locked),
      .q     (locked_s)
   );

   // Bit i is due for release once the release counter has reached i*STAGGER.
   genvar gi;
   generate
      for (gi = 0; gi < NUM_RST; gi++) begin : g_rel
         assign rel_mask[gi] = (cnt_reg >= CNT_W'(gi * STAGGER));
      end
   endgenerate

   always_ff @(posedge clk_in or negedge reset_n) begin
      if (!reset_n) begin
         state_reg <= ST_PLL_RST;
         cnt_reg   <= '0;
         retry_reg <= '0;
         flags_reg <= '{pll_reset: 1'b1, bypass: 1'b0, ready: 1'b0, fail: 1'b0};
         rst_n_reg <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         retry_reg <= retry_next;
         flags_reg <= flags_next;
         rst_n_reg <= rst_n_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      retry_next = retry_reg;
      flags_next = '{pll_reset: 1'b0, bypass: 1'b0, ready: 1'b0, fail: 1'b0};
      rst_n_next = '0;

      if (restart) begin
         state_next = ST_PLL_RST;
         cnt_next   = '0;
         retry_next = '0;
      end else begin
         case (state_reg)
            ST_PLL_RST: begin
               if (cnt_reg == CNT_PLL) begin
                  state_next = ST_WAIT_LOCK;
                  cnt_next   = '0;
               end else begin
                  cnt_next = cnt_reg + CNT_W'(1);
               end
            end
            ST_WAIT_LOCK: begin
               if (locked_s) begin
                  state_next = ST_STABLE;
                  cnt_next   = '0;
               end else if (cnt_reg == CNT_TO) begin
                  cnt_next = '0;
                  if (retry_reg < RETRY_MAX) begin
                     retry_next = retry_reg + RETRY_W'(1);
                     state_next = ST_PLL_RST;
                  end else begin
                     state_next = ST_FAIL;
                  end
               end else begin
                  cnt_next = cnt_reg + CNT_W'(1);
               end
            end
            ST_STABLE: begin
               if (!locked_s) begin
                  state_next = ST_WAIT_LOCK;
                  cnt_next   = '0;
               end else if (cnt_reg == CNT_STB) begin
                  state_next = ST_RELEASE;
                  cnt_next   = '0;
               end else begin
                  cnt_next = cnt_reg + CNT_W'(1);
               end
            end
            ST_RELEASE, ST_RUN: begin
               if (!locked_s) begin
                  cnt_next = '0;
                  if (retry_reg < RETRY_MAX) begin
                     retry_next = retry_reg + RETRY_W'(1);
                     state_next = ST_PLL_RST;
                  end else begin
                     state_next = ST_FAIL;
                  end
               end else if (state_reg == ST_RELEASE) begin
                  if (cnt_reg == CNT_REL) begin
                     state_next = ST_RUN;
                     retry_next = '0;
                  end else begin
                     cnt_next = cnt_reg + CNT_W'(1);
                  end
               end
            end
            ST_FAIL: begin
               // Counter saturates once every bypass release is due.
               if (cnt_reg != CNT_REL) cnt_next = cnt_reg + CNT_W'(1);
            end
            default: begin
               state_next = ST_PLL_RST;
               cnt_next   = '0;
            end
         endcase
      end

      // Outputs are decoded from the next state so they register with it.
      case (state_next)
         ST_PLL_RST: flags_next.pll_reset = 1'b1;
         ST_RELEASE: begin
            if (state_reg == ST_RELEASE) rst_n_next = rel_mask;
         end
         ST_RUN: begin
            flags_next.ready = 1'b1;
            rst_n_next       = '1;
         end
         ST_FAIL: begin
            flags_next.fail   = 1'b1;
            flags_next.bypass = (ALLOW_BYPASS != 0);
            if ((ALLOW_BYPASS != 0) && (state_reg == ST_FAIL)) rst_n_next = rel_mask;
         end
         default: ;
      endcase
   end

   assign pll_reset = flags_reg.pll_reset;
   assign bypass    = flags_reg.bypass;
   assign ready     = flags_reg.ready;
   assign fail      = flags_reg.fail;
   assign rst_n_out = rst_n_reg;
   assign retry_cnt = retry_reg;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed-plus-random bench for pll_reset_sequencer; expected event cycles are
// derived arithmetically from lock time, stable window, stagger and retry rules.
module tb_pll_reset_sequencer;

   localparam int N  = 4;
   localparam int P  = 16;
   localparam int TO = 200;
   localparam int S  = 50;
   localparam int T  = 8;
   localparam int MR = 3;
   localparam int AB = 1;
   localparam int RW = $clog2(MR + 1);
   localparam logic [N-1:0] ALL1 = '1;

   logic          clk_in  = 1'b0;
   logic          reset_n = 1'b0;
   logic          locked  = 1'b0;
   logic          restart = 1'b0;
   logic          pll_reset, bypass, ready, fail;
   logic [N-1:0]  rst_n_out;
   logic [RW-1:0] retry_cnt;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int rdy, k, d, lr, q, l3, g, x, f, e, l5, pulses, width;
   logic prev;

   always #5 clk_in = ~clk_in;

   pll_reset_sequencer #(
      .NUM_RST        (N),
      .PLL_RST_CYCLES (P),
      .LOCK_TIMEOUT   (TO),
      .LOCK_STABLE    (S),
      .STAGGER        (T),
      .MAX_RETRY      (MR),
      .ALLOW_BYPASS   (AB)
   ) dut (
      .clk_in    (clk_in),
      .reset_n   (reset_n),
      .locked    (locked),
      .restart   (restart),
      .pll_reset (pll_reset),
      .bypass    (bypass),
      .rst_n_out (rst_n_out),
      .ready     (ready),
      .fail      (fail),
      .retry_cnt (retry_cnt)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s at cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_in);
      @(negedge clk_in);
      cyc++;
   endtask

   // Downstream bits released by cycle c when release began at cycle r.
   function automatic logic [N-1:0] rel_model(input int r, input int c);
      logic [N-1:0] m;
      for (int i = 0; i < N; i++) m[i] = (c >= r + 1 + i * T);
      return m;
   endfunction

   task automatic check_idle(input string tag);
      check({tag, ".pll_reset"}, pll_reset, 1);
      check({tag, ".rst_n_out"}, rst_n_out, 0);
      check({tag, ".bypass"},    bypass,    0);
      check({tag, ".ready"},     ready,     0);
      check({tag, ".fail"},      fail,      0);
      check({tag, ".retry_cnt"}, retry_cnt, 0);
   endtask

   // Locked seen rising after cycle lock_cyc: STABLE 3 later, S stable cycles,
   // then the staggered release and RUN.
   task automatic follow(input int lock_cyc, input int retry_before, input int end_cyc);
      int r, rd;
      r  = lock_cyc + 3 + S;
      rd = r + 2 + (N - 1) * T;
      while (cyc < end_cyc) begin
         step();
         check("seq.rst_n_out", rst_n_out, rel_model(r, cyc));
         check("seq.ready",     ready,     (cyc >= rd) ? 1 : 0);
         check("seq.retry_cnt", retry_cnt, (cyc >= rd) ? 0 : retry_before);
         check("seq.pll_reset", pll_reset, 0);
      end
   endtask

   initial begin
      repeat (3) @(negedge clk_in);
      check_idle("reset_hold");
      reset_n = 1'b1;
      cyc     = 0;
      check_idle("reset_release");

      // Nominal lock 100 cycles after reset.
      while (cyc < 100) begin
         step();
         check("nom.pll_reset", pll_reset, (cyc < P) ? 1 : 0);
         check("nom.rst_n_out", rst_n_out, 0);
         check("nom.ready",     ready,     0);
      end
      locked = 1'b1;
      rdy = 100 + 5 + S + (N - 1) * T;
      follow(100, 0, rdy + 5);
      $display("nominal lock: ready expected at cycle %0d", rdy);

      // Lock loss in RUN, then relock.
      k = $urandom_range(1, 20);
      repeat (k) step();
      check("run.ready", ready, 1);
      d = cyc;
      locked = 1'b0;
      step();
      step();
      check("loss.rst_held", rst_n_out, ALL1);
      step();
      check("loss.rst_n_out", rst_n_out, 0);
      check("loss.ready",     ready,     0);
      check("loss.retry_cnt", retry_cnt, 1);
      check("loss.pll_reset", pll_reset, 1);
      lr = d + 3 + P + $urandom_range(0, 50);
      while (cyc < lr) begin
         step();
         check("loss.rst_low", rst_n_out, 0);
         check("loss.retry",   retry_cnt, 1);
      end
      locked = 1'b1;
      follow(lr, 1, lr + 5 + S + (N - 1) * T + 3);
      $display("lock loss at cycle %0d, relock at cycle %0d", d, lr);

      // Restart from RUN, then a 1-cycle glitch halfway through STABLE.
      q = cyc;
      restart = 1'b1;
      locked  = 1'b0;
      step();
      restart = 1'b0;
      check_idle("restart_run");
      l3 = q + P + 1 + $urandom_range(0, 40);
      while (cyc < l3) begin
         step();
         check("glitch.pre_lock", rst_n_out, 0);
      end
      locked = 1'b1;
      g = l3 + 3 + S / 2;
      while (cyc < g) begin
         step();
         check("glitch.rst_low", rst_n_out, 0);
         check("glitch.ready",   ready,     0);
      end
      locked = 1'b0;
      step();
      check("glitch.rst_low", rst_n_out, 0);
      locked = 1'b1;
      follow(g + 1, 0, g + 1 + 5 + S + (N - 1) * T + 2);
      $display("glitch at cycle %0d after lock at cycle %0d", g, l3);

      // Restart with lock held, then restart again mid-RELEASE.
      q = cyc;
      restart = 1'b1;
      step();
      restart = 1'b0;
      check_idle("restart_run2");
      while (cyc < q + P + 1) begin
         step();
         check("rs2.pll_reset", pll_reset, (cyc <= q + P) ? 1 : 0);
      end
      x = (q + P + 2 + S) + 1 + T + $urandom_range(0, T);
      follow(q + P - 1, 0, x);
      restart = 1'b1;
      locked  = 1'b0;
      step();
      restart = 1'b0;
      check_idle("restart_release");
      $display("restart mid-release at cycle %0d", x);

      // Never locks: four PLL init attempts, then FAIL with bypass release.
      f = x + 1 + 4 * (P + TO);
      pulses = 1;
      width  = 1;
      prev   = 1'b1;
      while (cyc < f + (N - 1) * T + 5) begin
         step();
         if (pll_reset && !prev) begin
            pulses++;
            width = 1;
         end else if (pll_reset) begin
            width++;
         end else if (prev) begin
            check("nolock.pulse_width", width, P);
         end
         prev = pll_reset;
         check("nolock.fail",      fail,      (cyc >= f) ? 1 : 0);
         check("nolock.bypass",    bypass,    (cyc >= f) ? AB : 0);
         check("nolock.ready",     ready,     0);
         check("nolock.rst_n_out", rst_n_out, rel_model(f, cyc));
         if (cyc == f) check("nolock.retry_cnt", retry_cnt, MR);
      end
      check("nolock.pulses", pulses, MR + 1);
      $display("never locks: fail expected at cycle %0d, pulses %0d", f, pulses);

      // Restart in FAIL, then lock and run.
      e = cyc;
      restart = 1'b1;
      step();
      restart = 1'b0;
      check_idle("restart_fail");
      l5 = e + P + 1 + $urandom_range(0, 30);
      while (cyc < l5) step();
      locked = 1'b1;
      rdy = l5 + 5 + S + (N - 1) * T;
      follow(l5, 0, rdy + $urandom_range(1, 10));
      $display("restart from fail: ready expected at cycle %0d", rdy);

      // Async reset between clock edges during RUN.
      @(posedge clk_in);
      #2;
      reset_n = 1'b0;
      #1;
      check_idle("async_reset");
      repeat (2) @(negedge clk_in);
      check_idle("async_reset_hold");
      reset_n = 1'b1;
      $display("async reset applied mid-cycle");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
